// File: rtl/controle_divisor.sv
// Multicycle front-end for the combinational ULA divider: holds the operands steady
// on div_a/div_b, captures Q/R (or flags divide-by-zero) and hands the result downstream.
module controle_divisor #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_a,
  input  logic [WIDTH-1:0] i_in_b,
  output logic [WIDTH-1:0] o_div_a,
  output logic [WIDTH-1:0] o_div_b,
  input  logic [WIDTH-1:0] i_div_q,
  input  logic [WIDTH-1:0] i_div_r,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_q,
  output logic [WIDTH-1:0] o_out_r,
  output logic             o_out_dz,
  output logic             o_busy
);

  // state    | meaning
  // S_IDLE   | waiting for an operand pair
  // S_SETTLE | operands held on the divider, counting down to capture
  // S_HOLD   | result presented, waiting for the consumer
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_div_a;
  logic [WIDTH-1:0] r_div_b;
  logic [WIDTH-1:0] r_out_q;
  logic [WIDTH-1:0] r_out_r;
  logic             r_out_dz;
  logic             w_take;
  logic             w_ready;
  logic             w_accept;
  logic             w_b_zero;
  logic             w_cnt_zero;

  assign w_b_zero   = (i_in_b == '0);
  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_take = 1'b0;
    case (r_state)
      S_IDLE:   w_take = 1'b1;
      S_SETTLE: if (w_cnt_zero) w_next = S_HOLD;
      S_HOLD: begin
        w_take = i_out_ready;
        if (i_out_ready) w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
    // readiness is masked during reset so nothing is taken while rst is high
    w_ready  = w_take & ~i_rst;
    w_accept = i_in_valid & w_ready;
    if (w_accept) w_next = w_b_zero ? S_HOLD : S_SETTLE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_div_a  <= '0;
      r_div_b  <= '0;
      r_out_q  <= '0;
      r_out_r  <= '0;
      r_out_dz <= 1'b0;
    end else if (w_accept) begin
      r_div_a <= i_in_a;
      r_div_b <= i_in_b;
      if (w_b_zero) begin
        r_out_q  <= '1;
        r_out_r  <= '0;
        r_out_dz <= 1'b1;
      end else begin
        r_cnt <= CNT_LOAD;
      end
    end else if (r_state == S_SETTLE) begin
      if (w_cnt_zero) begin
        r_out_q  <= i_div_q;
        r_out_r  <= i_div_r;
        r_out_dz <= 1'b0;
      end else begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign o_in_ready  = w_ready;
  assign o_div_a     = r_div_a;
  assign o_div_b     = r_div_b;
  assign o_out_valid = (r_state == S_HOLD);
  assign o_out_q     = r_out_q;
  assign o_out_r     = r_out_r;
  assign o_out_dz    = r_out_dz;
  assign o_busy      = (r_state != S_IDLE);

endmodule
